ether_tx: RTL
=============

// Module: ether_tx
// PURPOSE
// - RMII Ethernet transmitter: serialises one frame per request onto 2-bit ether_txd/ether_txen at 1 dibit/clk (50 MHz).
// - Frame: preamble, SFD, destination MAC, source MAC, 16-bit length, payload from an AXI-stream byte source, CRC-32 FCS, then inter-frame gap.
// - Transmit-side counterpart of the RMII receive path; a loopback into the RMII receiver must yield a valid frame.
// PARAMETERS
// - MAC_ADDRESS  48'hBEEFDEADFEFE  source address placed in every frame
// - IFG_CYCLES   48                idle clks after FCS (12 bytes x 4 dibits)
// - MAX_LENGTH   1500              largest legal tx_length
// PORTS
// - clk            in   1   50 MHz RMII reference clock
// - rst            in   1   synchronous, active-high reset
// - tx_start       in   1   frame request; sampled only when tx_busy=0
// - tx_dest        in   48  destination MAC, captured with tx_start
// - tx_length      in   16  payload byte count, captured with tx_start
// - s00_axis_tdata  in  8   payload byte
// - s00_axis_tvalid in  1   payload byte valid
// - s00_axis_tready out 1   byte accepted this clk when tvalid & tready
// - tx_busy        out  1   high from accepted start through end of IFG
// - tx_error       out  1   1-clk pulse: underrun or illegal length
// - ether_txd      out  2   RMII transmit dibit
// - ether_txen     out  1   RMII transmit enable
// BEHAVIOUR
// - Reset: state=IDLE; ether_txd=0, ether_txen=0, s00_axis_tready=0, tx_busy=0, tx_error=0; counters cleared; any frame in flight abandoned immediately (txen low next clk).
// - Bit order: each byte sent LSB dibit first ({b1,b0},{b3,b2},...); multi-byte fields (MACs, length) most-significant byte first.
// - Start: tx_start & !tx_busy at clk N captures tx_dest/tx_length; tx_busy=1 from N+1; first preamble dibit with ether_txen=1 at N+1.
// - tx_length > MAX_LENGTH: start ignored, tx_busy stays 0, tx_error pulses at N+1.
// - States: IDLE -> PREAMBLE (28 dibits 2'b01) -> SFD (01,01,01,11 = 8'hD5) -> DEST (6 B) -> SRC (6 B) -> LEN (2 B) -> DATA (tx_length B) -> [PAD] -> FCS (4 B) -> IFG (IFG_CYCLES clks, txen=0) -> IDLE.
// - tx_length=0: LEN goes directly to PAD/FCS; no tready asserted.
// - Byte counter 0..3 dibit phase, 11-bit byte index; each state exits on last dibit of its last byte, next state's first dibit on following clk (no bubbles).
// - Payload fetch: s00_axis_tready high for exactly one clk, the final dibit clk of the preceding byte (last LEN byte or previous DATA byte); byte loaded into shift register on handshake.
// - Underrun: tvalid=0 while tready=1 -> txen drops next clk, tx_error pulses, remaining payload not consumed, enter IFG (full gap), tx_busy held until IFG ends.
// - CRC-32: reflected poly 32'hEDB88320, init 32'hFFFFFFFF, updated 2 bits/clk over DEST..DATA/PAD dibits as sent; FCS = ~crc, sent bits [1:0] first through [31:30].
// - ether_txd/ether_txen registered; ether_txd=0 whenever ether_txen=0.
// - tx_start while tx_busy=1 ignored (no queueing).
// CONFIGURATION
// - ETHER_TX_PAD_EN defined: if tx_length < 46, after DATA emit 8'h00 bytes until 46 data-field bytes sent; length field still carries tx_length; pad bytes included in CRC.
// - ETHER_TX_PAD_EN undefined: PAD state absent; DATA goes straight to FCS for any length.
// TESTING
// - Reset then idle 100 clks -> ether_txen=0, ether_txd=0, tx_busy=0 throughout.
// - tx_start, dest 48'hFFFFFFFFFFFF, length 4, bytes DE AD BE EF -> 28x 01, SFD dibits 01,01,01,11, 14 header B, 4 payload B, 4 FCS B (no pad) or 42 pad B (PAD_EN); FCS matches software CRC-32; receiver loopback reports valid.
// - length 0 without PAD_EN -> exactly (8+14+4)*4=104 txen clks, tready never asserted, then 48 idle clks before tx_busy=0.
// - tvalid dropped at payload byte 2 of 10 -> txen low next clk, tx_error one pulse, tx_busy low 48 clks later.
// - tx_length 1501 -> no txen, tx_error pulse, tx_busy 0; back-to-back start raised during IFG -> ignored until tx_busy=0.
// - rst asserted mid-DATA -> next clk txen=0, tready=0, tx_busy=0; fresh start afterwards produces a correct frame.

Source files
------------

// File: rtl/ether_tx_if.sv
// ether_tx_if: AXI-stream byte channel feeding the payload into ether_tx.
interface ether_tx_if;
    logic [7:0] s00_axis_tdata;
    logic       s00_axis_tvalid;
    logic       s00_axis_tready;

    modport master (
        output s00_axis_tdata,
        output s00_axis_tvalid,
        input  s00_axis_tready
    );

    modport slave (
        input  s00_axis_tdata,
        input  s00_axis_tvalid,
        output s00_axis_tready
    );
endinterface

// File: rtl/ether_tx.sv
// ether_tx: RMII Ethernet transmitter, one frame per tx_start, one dibit per clk.
// Define ETHER_TX_PAD_EN to zero-pad short payloads up to the 46-byte minimum data field.
module ether_tx #(
    parameter logic [47:0] MAC_ADDRESS = 48'hBEEFDEADFEFE,
    parameter int unsigned IFG_CYCLES  = 48,
    parameter int unsigned MAX_LENGTH  = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [47:0] tx_dest,
    input  logic [15:0] tx_length,
    ether_tx_if.slave   s00_axis,
    output logic        tx_busy,
    output logic        tx_error,
    output logic [1:0]  ether_txd,
    output logic        ether_txen
);
    localparam int unsigned IDX_W    = 11;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
`ifdef ETHER_TX_PAD_EN
    localparam int unsigned PAD_MIN  = 46;
`endif

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, DEST, SRC, LEN, DATA,
`ifdef ETHER_TX_PAD_EN
        PAD,
`endif
        FCS, IFG
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ph_q, ph_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [47:0]        dest_q, dest_d;
    logic [15:0]        len_q, len_d;
    logic [7:0]         data_q, data_d;
    logic [31:0]        crc_q, crc_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               tready_q, tready_d;
    logic               txen_q, txen_d;
    logic [1:0]         txd_q, txd_d;

    logic [IDX_W-1:0]   last_idx;
    logic [7:0]         tx_byte;
    logic [31:0]        fcs;
    logic               crc_en;
    state_t             after_data;

    // Multi-byte fields go out most-significant byte first.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Reflected CRC-32 advanced by one dibit, bit 0 first as it goes on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // state_q/ph_q/idx_q always describe the dibit currently on txd_q.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        idx_d      = idx_q;
        dest_d     = dest_q;
        len_d      = len_q;
        data_d     = data_q;
        crc_d      = crc_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        tready_d   = 1'b0;
        txen_d     = 1'b0;
        txd_d      = 2'b00;
        last_idx   = '0;
        tx_byte    = 8'h00;
        crc_en     = 1'b0;
        fcs        = ~crc_q;
        after_data = FCS;
`ifdef ETHER_TX_PAD_EN
        if (len_q < 16'(PAD_MIN)) after_data = PAD;
`endif

        case (state_q)
            PREAMBLE:  last_idx = IDX_W'(6);
            DEST, SRC: last_idx = IDX_W'(5);
            LEN:       last_idx = IDX_W'(1);
            DATA:      last_idx = IDX_W'(len_q - 16'd1);
`ifdef ETHER_TX_PAD_EN
            PAD:       last_idx = IDX_W'(PAD_MIN - 1);
`endif
            FCS:       last_idx = IDX_W'(3);
            IFG:       last_idx = IDX_W'(IFG_CYCLES - 1);
            default:   last_idx = '0;
        endcase

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (tx_length > 16'(MAX_LENGTH)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = PREAMBLE;
                        ph_d    = '0;
                        idx_d   = '0;
                        dest_d  = tx_dest;
                        len_d   = tx_length;
                        busy_d  = 1'b1;
                        crc_d   = '1;
                    end
                end
            end
            IFG: begin
                if (idx_q == last_idx) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                // An offered fetch slot without tvalid abandons the frame.
                if (tready_q && !s00_axis.s00_axis_tvalid) begin
                    state_d = IFG;
                    ph_d    = '0;
                    idx_d   = '0;
                    err_d   = 1'b1;
                end else if (ph_q != 2'd3) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d  = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == last_idx) begin
                        idx_d = '0;
                        case (state_q)
                            PREAMBLE: state_d = SFD;
                            SFD:      state_d = DEST;
                            DEST:     state_d = SRC;
                            SRC:      state_d = LEN;
                            LEN:      state_d = (len_q == '0) ? after_data : DATA;
                            DATA:     state_d = after_data;
`ifdef ETHER_TX_PAD_EN
                            PAD:      state_d = FCS;
`endif
                            FCS:      state_d = IFG;
                            default:  state_d = IDLE;
                        endcase
`ifdef ETHER_TX_PAD_EN
                        // Pad index continues from the payload count up to PAD_MIN-1.
                        if (state_d == PAD) idx_d = IDX_W'(len_q);
`endif
                    end
                end
            end
        endcase

        case (state_d)
            PREAMBLE: tx_byte = 8'h55;
            SFD:      tx_byte = 8'hD5;
            DEST:     tx_byte = mac_byte(dest_q, 3'(idx_d));
            SRC:      tx_byte = mac_byte(MAC_ADDRESS, 3'(idx_d));
            LEN:      tx_byte = idx_d[0] ? len_q[7:0] : len_q[15:8];
            DATA: begin
                if (ph_d == 2'd0) data_d = s00_axis.s00_axis_tdata;
                tx_byte = data_d;
            end
            FCS:      tx_byte = fcs[{idx_d[1:0], 3'b000} +: 8];
            default:  tx_byte = 8'h00;
        endcase

        txen_d = (state_d != IDLE) && (state_d != IFG);
        if (txen_d) txd_d = tx_byte[{ph_d, 1'b0} +: 2];

        case (state_d)
            DEST, SRC, LEN, DATA: crc_en = 1'b1;
`ifdef ETHER_TX_PAD_EN
            PAD:                  crc_en = 1'b1;
`endif
            default:              crc_en = 1'b0;
        endcase
        if (crc_en) crc_d = crc_dibit(crc_q, txd_d);

        // Fetch slot is the last dibit clk of the byte preceding each payload byte.
        if (state_d == LEN && idx_d == IDX_W'(1) && ph_d == 2'd3 && len_q != '0) tready_d = 1'b1;
        if (state_d == DATA && ph_d == 2'd3 && idx_d != IDX_W'(len_q - 16'd1))   tready_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            idx_q    <= '0;
            dest_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            crc_q    <= '1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            tready_q <= 1'b0;
            txen_q   <= 1'b0;
            txd_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            idx_q    <= idx_d;
            dest_q   <= dest_d;
            len_q    <= len_d;
            data_q   <= data_d;
            crc_q    <= crc_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            tready_q <= tready_d;
            txen_q   <= txen_d;
            txd_q    <= txd_d;
        end
    end

    assign s00_axis.s00_axis_tready = tready_q;
    assign tx_busy    = busy_q;
    assign tx_error   = err_q;
    assign ether_txd  = txd_q;
    assign ether_txen = txen_q;
endmodule
